// File: rtl/output_buffer.sv
// DEPTH-entry FIFO between the shared data bus and the display, using a valid/ack handshake.
// When the FIFO is empty, display holds the last accepted value. Define OUTBUF_OVF_EN to add the sticky ovf flag.
module output_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       clr,
    input  logic                       wa,
    input  logic [WIDTH-1:0]           busin,
    input  logic                       out_ack,
    output logic [WIDTH-1:0]           display,
    output logic                       out_valid,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef OUTBUF_OVF_EN
    ,
    output logic                       ovf
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    occ;
    logic [WIDTH-1:0] last_value;

    logic             push;
    logic             pop;
    logic [CW-1:0]    occ_nxt;

    assign out_valid = (occ != '0);
    assign empty     = (occ == '0);
    assign full      = (occ == CW'(DEPTH));
    assign count     = occ;
    assign display   = out_valid ? mem[rd_ptr] : last_value;

    // When the FIFO is full, a write is accepted only if a pop frees a slot in the same cycle.
    always_comb begin
        pop     = out_valid && out_ack;
        push    = wa && (!full || pop);
        occ_nxt = occ;
        if (push && !pop)
            occ_nxt = occ + CW'(1);
        else if (pop && !push)
            occ_nxt = occ - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (clr_n && !clr && push)
            mem[wr_ptr] <= busin;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            last_value <= '0;
        end else if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            last_value <= '0;
        end else begin
            occ <= occ_nxt;
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                last_value <= mem[rd_ptr];
            end
        end
    end

`ifdef OUTBUF_OVF_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            ovf <= 1'b0;
        else if (clr)
            ovf <= 1'b0;
        else if (wa && full && !pop)
            ovf <= 1'b1;
    end
`endif

endmodule

// File: doc/output_buffer.md
Name: output_buffer

Overview:
- Parametrised successor to the single-register output stage.
- Captures bus values on write-enable into a DEPTH-entry FIFO and presents them to the display/consumer side with a valid/ack handshake.
- When the FIFO is empty, the display holds the last value the consumer accepted.
- Sits between the shared data bus and the output display/peripheral, so bursts of results are not lost when the consumer is slow.

Parameters:
- WIDTH, 8: data width of bus and display.
- DEPTH, 4: number of FIFO entries; power of 2, at least 2.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- clr_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear, active high.
- wa  input  1  write enable; push busin this cycle.
- busin  input  WIDTH  data from bus.
- out_ack  input  1  consumer accepts current display value.
- display  output  WIDTH  head entry when out_valid, else last accepted value.
- out_valid  output  1  FIFO non-empty.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (clr_n low, asynchronous):
  - Read/write pointers and count cleared to 0; last-value register cleared to 0.
  - Outputs: display=0, out_valid=0, empty=1, full=0, count=0.
  - Reset asserted mid-burst discards all entries immediately, without waiting for a clock edge.
- Sync clear (clr=1 at rising edge):
  - Same end state as reset.
  - Has priority over wa and out_ack in that cycle; nothing is pushed or popped.
- Push:
  - Occurs when wa=1 and (full=0, or a pop occurs in the same cycle).
  - busin is written at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop:
  - Occurs when out_valid=1 and out_ack=1.
  - The head value is copied into the last-value register; rd_ptr increments modulo DEPTH.
- out_ack while out_valid=0 is ignored.
- Simultaneous push and pop: both take effect and count is unchanged. This applies when full; a pop and push in the same cycle when full is accepted with no loss.
- Empty with wa=1 and out_ack=1: the push happens and the ack is ignored; count becomes 1.
- Full with wa=1 and no pop: the write is dropped; FIFO contents and pointers are unchanged.
- Latency: a value written at edge N appears on display with out_valid=1 after edge N (one cycle from wa sample). No bypass: an empty FIFO never shows busin combinationally.
- display mux (combinational):
  - mem[rd_ptr] when count != 0.
  - Otherwise the last-value register.
- count, full, empty, out_valid are registered or derived from registered count; they are glitch-free relative to clk.
- Pointers wrap silently at DEPTH-1 to 0; count saturates logically at DEPTH via the push rule and never exceeds it.

Optional Feature:
- Macro: OUTBUF_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), a sticky flag.
  - ovf is set at the edge where a write is dropped (wa=1, full=1, no pop).
  - ovf is cleared only by clr_n low or clr=1; clr takes priority over a set in the same cycle.
- Not defined:
  - The ovf port and its logic are absent.
  - Dropped writes are silent; all other behaviour is identical.

Test Plan:
- Reset: hold clr_n=0, then release -> display=0x00, out_valid=0, empty=1, count=0. Assert clr_n=0 asynchronously while count=3 -> count=0 and display=0x00 before the next edge.
- Single pass: wa=1 with busin=0xA5 for 1 cycle, out_ack=0 -> next cycle display=0xA5, out_valid=1, count=1. Then out_ack=1 for 1 cycle -> out_valid=0, display holds 0xA5.
- Fill/overflow (DEPTH=4): push 0x11, 0x22, 0x33, 0x44, then 0x55 -> full=1, count=4, 0x55 dropped (ovf=1 with OUTBUF_OVF_EN). Ack 4 times -> display sequence 0x11, 0x22, 0x33, 0x44, then holds 0x44 with empty=1.
- Full with simultaneous push and pop: at count=4, wa=1 with busin=0x66 and out_ack=1 -> count stays 4, 0x11 popped, 0x66 becomes the tail. Drain order: 0x22, 0x33, 0x44, 0x66.
- Pointer wrap: 10 push/pop pairs of 0x01..0x0A through DEPTH=4 with interleaved stalls -> order preserved, count never above 4, no loss.
- Sync clear priority: count=2 with clr=1, wa=1, out_ack=1 in the same cycle -> count=0, display=0x00, ovf=0; the busin value is not stored.
